button_event_arbiter: RTL and testbench
=======================================

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter REPEAT_DELAY, default 24'd12_500_000, cycles a button must stay held before its first auto-repeat event.
REQ-002 Parameter REPEAT_PERIOD, default 24'd2_500_000, cycles between later auto-repeat events.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset; sampled on rising clk only.
REQ-005 button_level  input  4  debounced button levels, synchronous to clk; 1 = pressed.
REQ-006 evt_ready  input  1  consumer accepts the offered event.
REQ-007 evt_valid  output  1  event offered.
REQ-008 evt_id  output  2  index of the button being offered.
REQ-009 evt_repeat  output  1  offered event is an auto-repeat, not an initial press.
REQ-010 pending  output  4  per-button event-pending flags.
REQ-011 drop_count  output  8  saturating count of presses merged into an already-pending flag.

Function
REQ-012 Registered button_prev SHALL track button_level; press[i] = button_level[i] & ~button_prev[i].
REQ-013 A press SHALL set pending[i] on the same edge that updates button_prev; pending SHALL be visible the cycle after the level rises.
REQ-014 A press on a button whose pending bit is already set, and not cleared that cycle, SHALL increment drop_count, saturating at 8'hFF.
REQ-015 FSM states: IDLE and OFFER.
REQ-016 IDLE: if pending != 0, load evt_id with the round-robin winner, set evt_valid = 1 and go to OFFER; otherwise stay.
REQ-017 Round-robin winner: the first set pending bit, searching upward from rr_ptr modulo 4.
REQ-018 OFFER: evt_valid, evt_id and evt_repeat SHALL hold stable until evt_ready = 1.
REQ-019 OFFER with evt_ready = 1: clear pending[evt_id], set rr_ptr = evt_id + 1 (mod 4), clear evt_valid, go to IDLE.
REQ-020 Two accepted events SHALL always be separated by at least one IDLE cycle.
REQ-021 Latency: button rises at edge n, pending set at edge n+1, evt_valid asserted at edge n+2 if the FSM was idle.
REQ-022 A press on the button whose event is being accepted in the same cycle SHALL re-set its pending bit (set wins) and SHALL NOT increment drop_count.
REQ-023 A release SHALL NOT clear a pending bit; a press-and-release still produces exactly one event.
REQ-024 evt_repeat SHALL be latched with evt_id when entering OFFER; it is 1 only for events raised by REQ-029.

Reset
REQ-025 When rst = 1 at a rising clk: evt_valid = 0, evt_id = 0, evt_repeat = 0, pending = 0, drop_count = 0, rr_ptr = 0, FSM = IDLE, and all repeat counters = 0.
REQ-026 Reset SHALL load button_prev = 4'hF, so a button held through reset produces no event until it is released and pressed again.
REQ-027 Reset asserted during OFFER SHALL abandon the offered event with no acceptance.

Configuration
REQ-028 Macro BTN_AUTOREPEAT_EN selects auto-repeat.
REQ-029 With BTN_AUTOREPEAT_EN defined:
  - each button has a 24-bit hold counter, cleared on press or release;
  - the counter increments while the button is held;
  - at REPEAT_DELAY-1, and then every REPEAT_PERIOD cycles, the button sets pending[i] with its repeat flag = 1;
  - an edge press clears the repeat flag;
  - a repeat onto an already-set pending bit is merged without counting in drop_count.
REQ-030 Without BTN_AUTOREPEAT_EN: no hold counters, evt_repeat tied to 0, and REPEAT_DELAY and REPEAT_PERIOD are ignored.

Verification
REQ-031 Single press: button_level 0000 -> 0001 at edge 10, evt_ready = 1 -> evt_valid = 1 with evt_id = 0 at edge 12; pending = 0000 at edge 13.
REQ-032 Fairness: button_level 0000 -> 1111 in one cycle, evt_ready = 1 -> evt_id sequence 0, 1, 2, 3, evt_valid low one cycle between events, drop_count = 0.
REQ-033 Backpressure: evt_ready = 0 for 50 cycles with button 2 pending -> evt_id = 2 held stable for all 50 cycles; three extra presses on button 2 -> drop_count = 3; after evt_ready = 1, exactly one event.
REQ-034 Reset with held button: button_level = 0100 held through and after reset -> no event; release then press -> one event with evt_id = 2.
REQ-035 Mid-offer reset: rst pulsed for 1 cycle during OFFER -> the next cycle shows evt_valid = 0, pending = 0, drop_count = 0.
REQ-036 Auto-repeat (BTN_AUTOREPEAT_EN, REPEAT_DELAY = 20, REPEAT_PERIOD = 8), button 1 held 44 cycles, evt_ready = 1 -> one event with evt_repeat = 0, then repeat events (evt_repeat = 1) at holds 20, 28, 36, 44; none after release.

Source files
------------

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: edge-detects four debounced buttons into per-button
// pending flags and offers them one at a time over a valid/ready handshake,
// chosen round-robin. Presses landing on an already-pending flag are counted
// in a saturating drop counter.
// Optional auto-repeat for held buttons: define BTN_AUTOREPEAT_EN.
module button_event_arbiter #(
    parameter logic [23:0] REPEAT_DELAY  = 24'd12_500_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] button_level,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    output logic       evt_repeat,
    output logic [3:0] pending,
    output logic [7:0] drop_count
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t     state_q, state_d;
    logic [3:0] button_prev;
    logic [3:0] press;
    logic [3:0] rpt_fire;
    logic [3:0] clr;
    logic [3:0] dropped;
    logic [3:0] pending_d;
    logic [1:0] rr_ptr;
    logic [1:0] winner;
    logic       load;
    logic       accept;
    logic [2:0] drop_inc;
    logic [8:0] drop_sum;

    assign press     = button_level & ~button_prev;
    assign clr       = accept ? (4'b0001 << evt_id) : 4'b0000;
    // set wins over clear, so a press on the button being accepted re-arms it
    assign dropped   = press & pending & ~clr;
    assign pending_d = (pending & ~clr) | press | rpt_fire;

    // round-robin pick: first pending bit at or above rr_ptr, wrapping mod 4
    always_comb begin
        winner = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (pending[rr_ptr + 2'(k)]) winner = rr_ptr + 2'(k);
        end
    end

    // count merged presses this cycle and add them with saturation
    always_comb begin
        drop_inc = 3'd0;
        for (int i = 0; i < 4; i++) drop_inc = drop_inc + {2'b00, dropped[i]};
        drop_sum = {1'b0, drop_count} + {6'd0, drop_inc};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and handshake strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    load    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // edge history, pending flags, drop counter and offered-event registers;
    // button_prev resets high so a button held through reset needs a fresh press
    always_ff @(posedge clk) begin
        if (rst) begin
            button_prev <= 4'hF;
            pending     <= 4'h0;
            drop_count  <= 8'h00;
            rr_ptr      <= 2'd0;
            evt_valid   <= 1'b0;
            evt_id      <= 2'd0;
        end else begin
            button_prev <= button_level;
            pending     <= pending_d;
            drop_count  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (load) begin
                evt_valid <= 1'b1;
                evt_id    <= winner;
            end
            if (accept) begin
                evt_valid <= 1'b0;
                rr_ptr    <= evt_id + 2'd1;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [3:0][23:0] hold_cnt;
    logic [3:0][23:0] hold_inc;
    logic [3:0]       held;
    logic [3:0]       rpt_flag;
    logic             rpt_q;

    assign held = button_level & button_prev;

    // repeat fires when the hold count reaches DELAY-1, then every PERIOD
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hold_inc[i] = hold_cnt[i] + 24'd1;
            rpt_fire[i] = held[i] &&
                          (hold_inc[i] == REPEAT_DELAY - 24'd1 ||
                           hold_inc[i] == REPEAT_DELAY - 24'd1 + REPEAT_PERIOD);
        end
    end

    // hold counters restart on any level change and fold back after each period;
    // repeat flag follows the most recent unmerged event source
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            rpt_flag <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!held[i])
                    hold_cnt[i] <= '0;
                else if (hold_inc[i] == REPEAT_DELAY - 24'd1 + REPEAT_PERIOD)
                    hold_cnt[i] <= REPEAT_DELAY - 24'd1;
                else
                    hold_cnt[i] <= hold_inc[i];
                if (press[i])
                    rpt_flag[i] <= 1'b0;
                else if (rpt_fire[i] && !(pending[i] && !clr[i]))
                    rpt_flag[i] <= 1'b1;
            end
        end
    end

    // repeat flag is captured alongside evt_id when the offer is loaded
    always_ff @(posedge clk) begin
        if (rst)       rpt_q <= 1'b0;
        else if (load) rpt_q <= rpt_flag[winner];
    end

    assign evt_repeat = rpt_q;
`else
    logic unused_cfg;

    assign rpt_fire   = 4'b0000;
    assign evt_repeat = 1'b0;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed testbench for button_event_arbiter. Inputs change 1ns after the
// rising edge; outputs are sampled at the same point.
module tb_button_event_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] button_level;
    logic       evt_ready;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_repeat;
    logic [3:0] pending;
    logic [7:0] drop_count;

    int checks   = 0;
    int failures = 0;

    button_event_arbiter #(.REPEAT_DELAY(24'd20), .REPEAT_PERIOD(24'd8)) dut (
        .clk(clk), .rst(rst), .button_level(button_level), .evt_ready(evt_ready),
        .evt_valid(evt_valid), .evt_id(evt_id), .evt_repeat(evt_repeat),
        .pending(pending), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; button_level = 4'h0; evt_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; button_level = 4'hF; evt_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({evt_valid, evt_id, evt_repeat, pending, drop_count} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state got v=%0b id=%0d r=%0b p=%h d=%0d exp all zero",
                     evt_valid, evt_id, evt_repeat, pending, drop_count);
        end
        rst = 1'b0; button_level = 4'h0;
        tick();
    endtask

    task automatic test_single_press();
        reset_dut();
        evt_ready = 1'b1;
        tick();
        button_level = 4'b0001;
        tick();
        checks++;
        if (pending !== 4'b0001 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pending got p=%b v=%0b exp p=0001 v=0", pending, evt_valid);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || evt_repeat !== 1'b0) begin
            failures++;
            $display("FAIL single_offer got v=%0b id=%0d r=%0b exp v=1 id=0 r=0", evt_valid, evt_id, evt_repeat);
        end
        tick();
        checks++;
        if (pending !== 4'b0000 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_accept got p=%b v=%0b exp p=0000 v=0", pending, evt_valid);
        end
        begin
            int extra = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (evt_valid) extra++;
            end
            checks++;
            if (extra !== 0) begin
                failures++;
                $display("FAIL single_held_no_event got=%0d exp=0", extra);
            end
        end
        button_level = 4'h0;
        tick();
    endtask

    task automatic test_fairness();
        reset_dut();
        evt_ready = 1'b1;
        tick();
        button_level = 4'hF;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (i % 2 == 0) begin
                if (evt_valid !== 1'b1 || evt_id !== 2'(i / 2) || evt_repeat !== 1'b0) begin
                    failures++;
                    $display("FAIL fair_offer%0d got v=%0b id=%0d exp v=1 id=%0d", i / 2, evt_valid, evt_id, i / 2);
                end
            end else if (evt_valid !== 1'b0) begin
                failures++;
                $display("FAIL fair_gap%0d got v=%0b exp v=0", i / 2, evt_valid);
            end
        end
        checks++;
        if (drop_count !== 8'd0 || pending !== 4'h0) begin
            failures++;
            $display("FAIL fair_end got d=%0d p=%b exp d=0 p=0000", drop_count, pending);
        end
        button_level = 4'h0;
        tick();
    endtask

    task automatic test_round_robin();
        reset_dut();
        evt_ready = 1'b1;
        tick();
        button_level = 4'b0001;
        tick(); tick(); tick();
        button_level = 4'b0000;
        tick();
        button_level = 4'b0101;
        tick(); tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            failures++;
            $display("FAIL rr_first got v=%0b id=%0d exp v=1 id=2", evt_valid, evt_id);
        end
        tick(); tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            failures++;
            $display("FAIL rr_second got v=%0b id=%0d exp v=1 id=0", evt_valid, evt_id);
        end
        button_level = 4'h0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int extra = 0;
        reset_dut();
        tick();
        button_level = 4'b0100;
        tick(); tick();
        for (int i = 0; i < 50; i++) begin
            case (i)
                5, 15, 25, 35: button_level = 4'b0000;
                8, 18, 28:     button_level = 4'b0100;
                default: ;
            endcase
            tick();
            if (evt_valid !== 1'b1 || evt_id !== 2'd2) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_stable got bad_cycles=%0d exp=0", bad);
        end
        checks++;
        if (drop_count !== 8'd3) begin
            failures++;
            $display("FAIL bp_drops got=%0d exp=3", drop_count);
        end
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'h0) begin
            failures++;
            $display("FAIL bp_accept got v=%0b p=%b exp v=0 p=0000", evt_valid, pending);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (evt_valid) extra++;
        end
        checks++;
        if (extra !== 0) begin
            failures++;
            $display("FAIL bp_single_event got extra=%0d exp=0", extra);
        end
    endtask

    task automatic test_accept_press();
        reset_dut();
        tick();
        button_level = 4'b0001;
        tick(); tick();
        button_level = 4'b0000;
        tick();
        evt_ready = 1'b1;
        button_level = 4'b0001;
        tick();
        checks++;
        if (pending !== 4'b0001 || drop_count !== 8'd0 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL acc_press got p=%b d=%0d v=%0b exp p=0001 d=0 v=0", pending, drop_count, evt_valid);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            failures++;
            $display("FAIL acc_reoffer got v=%0b id=%0d exp v=1 id=0", evt_valid, evt_id);
        end
        tick();
        button_level = 4'h0;
        tick();
    endtask

    task automatic test_reset_held();
        int seen = 0;
        rst = 1'b1; button_level = 4'b0100; evt_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (evt_valid || pending != 4'h0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL held_rst_no_event got=%0d exp=0", seen);
        end
        button_level = 4'b0000;
        tick();
        button_level = 4'b0100;
        tick(); tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            failures++;
            $display("FAIL held_rst_repress got v=%0b id=%0d exp v=1 id=2", evt_valid, evt_id);
        end
        tick();
        button_level = 4'h0;
        tick();
    endtask

    task automatic test_mid_offer_reset();
        int seen = 0;
        reset_dut();
        tick();
        button_level = 4'b0010;
        tick(); tick();
        button_level = 4'b0000;
        tick();
        button_level = 4'b0010;
        tick();
        checks++;
        if (drop_count !== 8'd1 || evt_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got d=%0d v=%0b exp d=1 v=1", drop_count, evt_valid);
        end
        rst = 1'b1; button_level = 4'b0000;
        tick();
        rst = 1'b0;
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'h0 || drop_count !== 8'd0) begin
            failures++;
            $display("FAIL mid_reset got v=%0b p=%b d=%0d exp v=0 p=0000 d=0", evt_valid, pending, drop_count);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (evt_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL mid_abandoned got events=%0d exp=0", seen);
        end
    endtask

    task automatic test_drop_saturate();
        reset_dut();
        tick();
        button_level = 4'b1000;
        tick();
        for (int i = 0; i < 260; i++) begin
            button_level = 4'b0000;
            tick();
            button_level = 4'b1000;
            tick();
        end
        checks++;
        if (drop_count !== 8'hFF) begin
            failures++;
            $display("FAIL drop_saturate got=%h exp=ff", drop_count);
        end
        button_level = 4'h0;
        tick();
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int n_evt = 0;
        int exp_k[5] = '{2, 21, 29, 37, 45};
        int got_k[5];
        logic got_r[5];
        reset_dut();
        evt_ready = 1'b1;
        tick();
        button_level = 4'b0010;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 44) button_level = 4'b0000;
            if (evt_valid) begin
                if (n_evt < 5) begin
                    got_k[n_evt] = k;
                    got_r[n_evt] = evt_repeat;
                end
                n_evt++;
            end
        end
        checks++;
        if (n_evt !== 5) begin
            failures++;
            $display("FAIL rpt_count got=%0d exp=5", n_evt);
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (got_k[j] !== exp_k[j] || got_r[j] !== (j != 0)) begin
                    failures++;
                    $display("FAIL rpt_evt%0d got cyc=%0d r=%0b exp cyc=%0d r=%0b",
                             j, got_k[j], got_r[j], exp_k[j], (j != 0));
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_press();
        test_fairness();
        test_round_robin();
        test_back_to_back();
        test_accept_press();
        test_reset_held();
        test_mid_offer_reset();
        test_drop_saturate();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
